input_conditioner: RTL and testbench
====================================

INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter N_IN, default 5: number of conditioned inputs (4 switches + 1 button).
REQ-002 Parameter DEBOUNCE_CYCLES, default 1250000: consecutive stable cycles required before accepting a change (10 ms at 125 MHz); legal range 1..2^24-1.
REQ-003 CLOCK  input  1  single system clock, 125 MHz; all logic on its rising edge.
REQ-004 RESET_N  input  1  synchronous, active-low reset.
REQ-005 RAW_IN  input  N_IN  asynchronous mechanical switch/button levels.
REQ-006 CLEAN  output  N_IN  debounced, synchronised level per input.
REQ-007 RISE  output  N_IN  one-cycle pulse per input on accepted 0->1 change of CLEAN.
REQ-008 FALL  output  N_IN  one-cycle pulse per input on accepted 1->0 change of CLEAN.
REQ-009 ANY_RISE  output  1  OR-reduction of RISE, same cycle.

Function
REQ-010 Each RAW_IN bit SHALL pass through a two-flop synchroniser before any other use; no combinational path from RAW_IN to outputs.
REQ-011 Each channel SHALL hold an independent stability counter of width clog2(DEBOUNCE_CYCLES+1).
REQ-012 When the synchronised bit equals CLEAN, the counter SHALL be cleared to 0 that cycle.
REQ-013 When the synchronised bit differs from CLEAN and the counter is below DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-014 When the synchronised bit differs from CLEAN and the counter equals DEBOUNCE_CYCLES-1, CLEAN SHALL take the synchronised value and the counter SHALL clear, both on the same edge.
REQ-015 Any mismatch-free cycle before acceptance (glitch) SHALL restart the count from 0; no partial credit.
REQ-016 Latency: a RAW_IN change held stable is reflected on CLEAN exactly 2 + DEBOUNCE_CYCLES rising edges after the first edge that samples it.
REQ-017 RISE/FALL SHALL be registered, asserted for exactly one cycle in the same cycle CLEAN changes, never both for one channel simultaneously.
REQ-018 Channels SHALL be fully independent; simultaneous acceptances on several channels SHALL pulse each corresponding RISE/FALL bit in the same cycle.
REQ-019 Counter SHALL never wrap; saturation is impossible by REQ-014.
REQ-020 With DEBOUNCE_CYCLES=1, a mismatch SHALL be accepted on the first mismatching synchronised cycle.

Reset
REQ-021 While RESET_N is low at a rising edge, synchroniser flops, CLEAN, counters, RISE, FALL and ANY_RISE SHALL all be 0 after that edge.
REQ-022 An input high across reset release SHALL be treated as a 0->1 change: CLEAN rises and RISE pulses once after the REQ-016 latency.
REQ-023 Reset asserted mid-count SHALL discard the count; no pulse SHALL be emitted for the pre-reset change.

Structure
REQ-024 DEBOUNCE_CYCLES default, counter-width function and N_IN default SHALL live in shared package input_cond_pkg.
REQ-025 Per-channel logic (synchroniser, counter, CLEAN flop, edge pulses) SHALL be one sub-module debounce_bit, instantiated N_IN times via generate; top adds only ANY_RISE.

Verification (bench uses DEBOUNCE_CYCLES=4, N_IN=5)
REQ-026 Reset, RAW_IN=0 -> all outputs 0; RAW_IN[0] 0->1 held -> CLEAN[0]=1 and RISE[0]=1 for one cycle exactly 6 edges later, ANY_RISE same cycle.
REQ-027 RAW_IN[2] high 3 synchronised cycles then low 1 cycle, repeated 10 times -> CLEAN[2] stays 0, no RISE/FALL pulses.
REQ-028 RAW_IN=5'b10101 applied in one cycle -> RISE=5'b10101 in a single cycle 6 edges later; later 5'b00000 -> FALL=5'b10101 one cycle.
REQ-029 RAW_IN[4]=1 held through reset release -> RISE[4] pulses once 6 edges after first post-reset edge.
REQ-030 RESET_N low for one cycle while RAW_IN[1] count is at 2 -> counter restarts, CLEAN[1] rises 6 edges after reset release, one RISE[1] only.
REQ-031 Random RAW_IN bursts, 10k cycles -> scoreboard: RISE/FALL always single-cycle, never coincident per channel, CLEAN matches reference debounce model.

Source files
------------

// File: rtl/input_cond_pkg.sv
// Shared defaults and helpers for the input conditioner and its per-channel debouncer.
package input_cond_pkg;

  localparam int N_IN_DEFAULT            = 5;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 1250000;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_FALL = 2'd2
  } edge_e;

  // Counter must hold DEBOUNCE_CYCLES-1 without wrapping; width never drops below 1.
  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One conditioned channel: two-flop synchroniser, stability counter, clean level and edge pulses.
module debounce_bit
  import input_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall
);

  localparam int               CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] count;
  logic             mismatch;
  logic             accept;
  edge_e            edge_kind;

  always_comb begin
    mismatch  = sync[1] ^ clean;
    accept    = mismatch && (count == LAST);
    edge_kind = EDGE_NONE;
    if (accept) begin
      edge_kind = sync[1] ? EDGE_RISE : EDGE_FALL;
    end
  end

  // Any matching cycle before acceptance throws away the partial count.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync  <= '0;
      count <= '0;
      clean <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      rise <= (edge_kind == EDGE_RISE);
      fall <= (edge_kind == EDGE_FALL);
      if (!mismatch) begin
        count <= '0;
      end else if (accept) begin
        clean <= sync[1];
        count <= '0;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Debounces N_IN mechanical inputs independently and flags any accepted rising edge.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int N_IN            = N_IN_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [N_IN-1:0] raw_in,
  output logic [N_IN-1:0] clean,
  output logic [N_IN-1:0] rise,
  output logic [N_IN-1:0] fall,
  output logic            any_rise
);

  for (genvar i = 0; i < N_IN; i++) begin : g_chan
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clock  (clock),
      .reset_n(reset_n),
      .raw    (raw_in[i]),
      .clean  (clean[i]),
      .rise   (rise[i]),
      .fall   (fall[i])
    );
  end

  // Built from registered pulses, so no raw input reaches this output combinationally.
  assign any_rise = |rise;

endmodule

// File: tb/tb_input_conditioner.sv
// Randomised and directed bench for input_conditioner against a sliding-window debounce model.
module tb_input_conditioner;

  localparam int N = 5;
  localparam int D = 4;

  logic         clock = 1'b0;
  logic         reset_n;
  logic [N-1:0] raw_in;
  logic [N-1:0] clean;
  logic [N-1:0] rise;
  logic [N-1:0] fall;
  logic         any_rise;

  int vectors     = 0;
  int miscompares = 0;
  int rise_cnt[N];
  int fall_cnt[N];

  // Model: raw samples take two edges to become visible; a channel flips once the
  // last D visible samples since reset all disagree with its clean level.
  logic [N-1:0] raw_q[$];
  logic [N-1:0] sync_hist[$];
  logic [N-1:0] m_clean;
  logic [N-1:0] m_rise;
  logic [N-1:0] m_fall;

  always #4 clock = ~clock;

  input_conditioner #(
    .N_IN(N),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .raw_in  (raw_in),
    .clean   (clean),
    .rise    (rise),
    .fall    (fall),
    .any_rise(any_rise)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelStep(input logic [N-1:0] raw, input logic rst_n);
    logic [N-1:0] s;
    bit           all_diff;
    m_rise = '0;
    m_fall = '0;
    if (!rst_n) begin
      raw_q.delete();
      raw_q.push_back('0);
      raw_q.push_back('0);
      sync_hist.delete();
      m_clean = '0;
    end else begin
      s = raw_q.pop_front();
      raw_q.push_back(raw);
      sync_hist.push_back(s);
      if (sync_hist.size() > D) void'(sync_hist.pop_front());
      for (int c = 0; c < N; c++) begin
        all_diff = (sync_hist.size() == D);
        foreach (sync_hist[k]) begin
          if (sync_hist[k][c] == m_clean[c]) all_diff = 1'b0;
        end
        if (all_diff) begin
          m_clean[c] = ~m_clean[c];
          if (m_clean[c]) m_rise[c] = 1'b1;
          else            m_fall[c] = 1'b1;
        end
      end
    end
  endtask

  task automatic clearCounts();
    for (int c = 0; c < N; c++) begin
      rise_cnt[c] = 0;
      fall_cnt[c] = 0;
    end
  endtask

  // One clock: drive on the falling edge, step the model on the rising edge, check just after.
  task automatic applyStimulus(input logic [N-1:0] raw, input logic rst_n);
    @(negedge clock);
    raw_in  = raw;
    reset_n = rst_n;
    @(posedge clock);
    modelStep(raw, rst_n);
    #1;
    checkOutput("clean", clean, m_clean);
    checkOutput("rise", rise, m_rise);
    checkOutput("fall", fall, m_fall);
    checkOutput("any_rise", any_rise, |m_rise);
    checkOutput("rise_fall_overlap", rise & fall, 0);
    for (int c = 0; c < N; c++) begin
      rise_cnt[c] += rise[c];
      fall_cnt[c] += fall[c];
    end
  endtask

  initial begin
    logic [N-1:0] cur;
    int           hold;
    int           cycles;

    raw_in  = '0;
    reset_n = 1'b0;
    clearCounts();

    repeat (3) applyStimulus('0, 1'b0);
    checkOutput("reset_clean", clean, 0);
    checkOutput("reset_pulses", {rise, fall, any_rise}, 0);
    repeat (2) applyStimulus('0, 1'b1);

    // Single rising input: accepted on the sixth edge after it is first sampled.
    clearCounts();
    for (int t = 1; t <= 6; t++) begin
      applyStimulus(5'b00001, 1'b1);
      if (t == 5) checkOutput("lat_pre_clean0", clean[0], 0);
    end
    checkOutput("lat_clean0", clean[0], 1);
    checkOutput("lat_rise", rise, 5'b00001);
    checkOutput("lat_any_rise", any_rise, 1);
    applyStimulus(5'b00001, 1'b1);
    checkOutput("lat_rise_once", rise, 0);
    repeat (8) applyStimulus('0, 1'b1);
    checkOutput("lat_fall_count0", fall_cnt[0], 1);

    // Three-cycle glitches never reach the four-cycle threshold.
    clearCounts();
    repeat (10) begin
      repeat (3) applyStimulus(5'b00100, 1'b1);
      applyStimulus('0, 1'b1);
    end
    repeat (4) applyStimulus('0, 1'b1);
    checkOutput("glitch_clean2", clean[2], 0);
    checkOutput("glitch_pulses2", rise_cnt[2] + fall_cnt[2], 0);

    // Several channels accepted together.
    for (int t = 1; t <= 6; t++) applyStimulus(5'b10101, 1'b1);
    checkOutput("multi_rise", rise, 5'b10101);
    repeat (2) applyStimulus(5'b10101, 1'b1);
    for (int t = 1; t <= 6; t++) applyStimulus('0, 1'b1);
    checkOutput("multi_fall", fall, 5'b10101);
    checkOutput("multi_clean", clean, 0);

    // Input held high across reset release.
    repeat (2) applyStimulus(5'b10000, 1'b0);
    clearCounts();
    for (int t = 1; t <= 6; t++) applyStimulus(5'b10000, 1'b1);
    checkOutput("rel_rise4", rise, 5'b10000);
    repeat (4) applyStimulus(5'b10000, 1'b1);
    checkOutput("rel_rise4_count", rise_cnt[4], 1);
    repeat (8) applyStimulus('0, 1'b1);

    // Reset mid-count discards the partial count.
    clearCounts();
    repeat (4) applyStimulus(5'b00010, 1'b1);
    applyStimulus(5'b00010, 1'b0);
    for (int t = 1; t <= 6; t++) begin
      applyStimulus(5'b00010, 1'b1);
      if (t == 5) checkOutput("midrst_pre_clean1", clean[1], 0);
    end
    checkOutput("midrst_clean1", clean[1], 1);
    repeat (4) applyStimulus(5'b00010, 1'b1);
    checkOutput("midrst_rise1_count", rise_cnt[1], 1);

    // Random bursts with occasional resets.
    cur    = '0;
    cycles = 0;
    while (cycles < 10000) begin
      cur  = cur ^ N'($urandom);
      hold = $urandom_range(1, 8);
      for (int h = 0; h < hold; h++) begin
        applyStimulus(cur, ($urandom_range(0, 499) != 0));
        cycles++;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
